// File: rtl/dti_dmem_pkg.sv
// Shared types and lane helpers for the dti data-memory responder: size and FSM
// encodings, byte-lane masks, alignment rule and load/store lane steering.
package dti_dmem_pkg;

  typedef enum logic [1:0] {
    DMEM_SIZE_BYTE = 2'b00,
    DMEM_SIZE_HALF = 2'b01,
    DMEM_SIZE_WORD = 2'b10,
    DMEM_SIZE_RSVD = 2'b11
  } dmem_size_e;

  typedef enum logic [1:0] {
    DMEM_IDLE = 2'b00,
    DMEM_WAIT = 2'b01,
    DMEM_ACK  = 2'b10
  } dmem_state_e;

  localparam logic [15:0] ERR_COUNT_MAX = 16'hFFFF;

  // Reserved size is treated as a misaligned access.
  function automatic logic is_aligned(input dmem_size_e size, input logic [1:0] lane);
    case (size)
      DMEM_SIZE_BYTE: is_aligned = 1'b1;
      DMEM_SIZE_HALF: is_aligned = ~lane[0];
      DMEM_SIZE_WORD: is_aligned = (lane == 2'b00);
      default:        is_aligned = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] lane_mask(input dmem_size_e size, input logic [1:0] lane);
    case (size)
      DMEM_SIZE_BYTE: lane_mask = 4'b0001 << lane;
      DMEM_SIZE_HALF: lane_mask = 4'b0011 << {lane[1], 1'b0};
      DMEM_SIZE_WORD: lane_mask = 4'b1111;
      default:        lane_mask = 4'b0000;
    endcase
  endfunction

  // Replicate right-justified store data so every lane the mask can select carries it.
  function automatic logic [31:0] store_lanes(input dmem_size_e size, input logic [31:0] data);
    case (size)
      DMEM_SIZE_BYTE: store_lanes = {4{data[7:0]}};
      DMEM_SIZE_HALF: store_lanes = {2{data[15:0]}};
      default:        store_lanes = data;
    endcase
  endfunction

  function automatic logic [31:0] load_extract(input dmem_size_e size, input logic [1:0] lane,
                                               input logic [31:0] word);
    logic [31:0] shifted;
    shifted = word >> {lane, 3'b000};
    case (size)
      DMEM_SIZE_BYTE: load_extract = {24'h000000, shifted[7:0]};
      DMEM_SIZE_HALF: load_extract = {16'h0000, shifted[15:0]};
      DMEM_SIZE_WORD: load_extract = word;
      default:        load_extract = 32'h0000_0000;
    endcase
  endfunction

endpackage

// File: rtl/dti_dmem_array.sv
// Single-port 32-bit word array with per-byte write enables and a registered,
// enable-gated read port.
module dti_dmem_array #(
  parameter int    DEPTH_WORDS = 1024,
  parameter int    IDX_W       = $clog2(DEPTH_WORDS),
  parameter string INIT_FILE   = ""
) (
  input  logic             clk,
  input  logic             rd_en,
  input  logic [3:0]       wr_be,
  input  logic [IDX_W-1:0] idx,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // NOTE: the array and its read register have no reset; contents survive reset by design
  // and a reset on a RAM would prevent block-memory inference.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (wr_be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
    end
    if (rd_en) rdata <= mem[idx];
  end

endmodule

// File: rtl/dti_dmem_responder.sv
// Memory-side end of the dti_riscv_core dmem request/ack interface: one access at a time,
// WAIT_CYCLES wait states, little-endian byte/half/word lanes, one-cycle acknowledge.
module dti_dmem_responder
  import dti_dmem_pkg::*;
#(
  parameter int    ADDR_WIDTH  = 32,
  parameter int    DATA_WIDTH  = 32,
  parameter int    DEPTH_WORDS = 1024,
  parameter int    WAIT_CYCLES = 1,
  parameter string INIT_FILE   = ""
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] dmem_address,
  input  logic [DATA_WIDTH-1:0] dmem_data_out,
  input  logic [1:0]            dmem_data_size,
  input  logic                  dmem_read_req,
  input  logic                  dmem_write_req,
  output logic [31:0]           dmem_data_in,
  output logic                  dmem_read_ack,
  output logic                  dmem_write_ack,
  output logic [15:0]           err_count
);

  localparam int         IDX_W     = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

  dmem_state_e state, state_next;
  logic [3:0]  wait_cnt;
  logic        req;
  dmem_size_e  in_size;

  logic [IDX_W-1:0] cap_idx;
  logic [1:0]       cap_lane;
  dmem_size_e       cap_size;
  logic [31:0]      cap_data;
  logic             cap_write;
  logic             cap_misalign;
  logic             cap_dual;

  logic [IDX_W-1:0] acc_idx;
  logic [1:0]       acc_lane;
  dmem_size_e       acc_size;
  logic             acc_load;

  logic        enter_ack;
  logic        arr_rd_en;
  logic [3:0]  arr_be;
  logic [31:0] rd_word;

  logic [1:0]  ld_lane;
  dmem_size_e  ld_size;
  logic        ld_zero;

  logic        unused_addr_hi;

  assign req            = dmem_read_req | dmem_write_req;
  assign in_size        = dmem_size_e'(dmem_data_size);
  assign unused_addr_hi = ^dmem_address[ADDR_WIDTH-1:IDX_W+2];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state <= DMEM_IDLE;
    else       state <= state_next;
  end

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      DMEM_IDLE: if (req) state_next = (WAIT_CYCLES == 0) ? DMEM_ACK : DMEM_WAIT;
      DMEM_WAIT: if (wait_cnt == 4'd1) state_next = DMEM_ACK;
      DMEM_ACK:  state_next = DMEM_IDLE;
      default:   state_next = DMEM_IDLE;
    endcase
  end

  always_comb begin
    dmem_read_ack  = 1'b0;
    dmem_write_ack = 1'b0;
    if (state == DMEM_ACK) begin
      dmem_read_ack  = ~cap_write;
      dmem_write_ack = cap_write;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)                          wait_cnt <= 4'd0;
    else if (state == DMEM_IDLE && req) wait_cnt <= WAIT_LOAD;
    else if (state == DMEM_WAIT)        wait_cnt <= wait_cnt - 4'd1;
  end

  // Captured request; only consumed in WAIT/ACK, which reset never leaves the FSM in.
  // A dual request is captured as a store.
  always_ff @(posedge clk) begin
    if (state == DMEM_IDLE && req) begin
      cap_idx      <= dmem_address[IDX_W+1:2];
      cap_lane     <= dmem_address[1:0];
      cap_size     <= in_size;
      cap_data     <= dmem_data_out[31:0];
      cap_write    <= dmem_write_req;
      cap_misalign <= ~is_aligned(in_size, dmem_address[1:0]);
      cap_dual     <= dmem_read_req & dmem_write_req;
    end
  end

  // With zero wait states the access enters ACK straight from IDLE, so the array read
  // must be steered from the live request rather than the capture registers.
  always_comb begin
    if (state == DMEM_IDLE) begin
      acc_idx  = dmem_address[IDX_W+1:2];
      acc_lane = dmem_address[1:0];
      acc_size = in_size;
      acc_load = dmem_read_req & ~dmem_write_req;
    end else begin
      acc_idx  = cap_idx;
      acc_lane = cap_lane;
      acc_size = cap_size;
      acc_load = ~cap_write;
    end
  end

  assign enter_ack = (state_next == DMEM_ACK) && !reset;
  assign arr_rd_en = enter_ack && acc_load;
  assign arr_be    = (state == DMEM_ACK && cap_write && !cap_misalign && !reset)
                   ? lane_mask(cap_size, cap_lane) : 4'b0000;

  dti_dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W),
    .INIT_FILE   (INIT_FILE)
  ) u_array (
    .clk   (clk),
    .rd_en (arr_rd_en),
    .wr_be (arr_be),
    .idx   (acc_idx),
    .wdata (store_lanes(cap_size, cap_data)),
    .rdata (rd_word)
  );

  // Load steering state only moves on a load, so dmem_data_in holds across stores.
  always_ff @(posedge clk) begin
    if (reset)          ld_zero <= 1'b1;
    else if (arr_rd_en) ld_zero <= ~is_aligned(acc_size, acc_lane);
  end

  always_ff @(posedge clk) begin
    if (arr_rd_en) begin
      ld_lane <= acc_lane;
      ld_size <= acc_size;
    end
  end

  assign dmem_data_in = ld_zero ? 32'h0000_0000 : load_extract(ld_size, ld_lane, rd_word);

  always_ff @(posedge clk) begin
    if (reset) begin
      err_count <= 16'h0000;
    end else if (state == DMEM_ACK && (cap_misalign || cap_dual) && err_count != ERR_COUNT_MAX) begin
      err_count <= err_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_dti_dmem_responder.sv
// Randomised and directed bench for dti_dmem_responder against a byte-addressed
// reference memory; unit 0 runs with one wait state, unit 1 with four.
module tb_dti_dmem_responder;

  logic        clk;
  logic        rst      [2];
  logic [31:0] addr_in  [2];
  logic [31:0] wdata_in [2];
  logic [1:0]  size_in  [2];
  logic        rd_req   [2];
  logic        wr_req   [2];
  logic [31:0] data_in  [2];
  logic        rd_ack   [2];
  logic        wr_ack   [2];
  logic [15:0] err      [2];

  int n_tests = 0;
  int n_fail  = 0;

  // Reference: 4 KiB of bytes per unit, last load value and error count.
  logic [7:0]  mb [2][4096];
  logic [31:0] model_last [2];
  int          model_err  [2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  dti_dmem_responder #(.WAIT_CYCLES(1)) dut (
    .clk(clk), .reset(rst[0]), .dmem_address(addr_in[0]), .dmem_data_out(wdata_in[0]),
    .dmem_data_size(size_in[0]), .dmem_read_req(rd_req[0]), .dmem_write_req(wr_req[0]),
    .dmem_data_in(data_in[0]), .dmem_read_ack(rd_ack[0]), .dmem_write_ack(wr_ack[0]),
    .err_count(err[0])
  );

  dti_dmem_responder #(.WAIT_CYCLES(4)) dut_w4 (
    .clk(clk), .reset(rst[1]), .dmem_address(addr_in[1]), .dmem_data_out(wdata_in[1]),
    .dmem_data_size(size_in[1]), .dmem_read_req(rd_req[1]), .dmem_write_req(wr_req[1]),
    .dmem_data_in(data_in[1]), .dmem_read_ack(rd_ack[1]), .dmem_write_ack(wr_ack[1]),
    .err_count(err[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int wait_of(input int u);
    return (u == 0) ? 1 : 4;
  endfunction

  function automatic int nbytes(input logic [1:0] sz);
    case (sz)
      2'd0:    return 1;
      2'd1:    return 2;
      2'd2:    return 4;
      default: return 0;
    endcase
  endfunction

  function automatic bit misaligned(input logic [31:0] a, input logic [1:0] sz);
    int n;
    n = nbytes(sz);
    return (n == 0) || ((int'(a[1:0]) % n) != 0);
  endfunction

  function automatic logic [31:0] model_load(input int u, input logic [31:0] a, input logic [1:0] sz);
    logic [31:0] v;
    v = 32'h0;
    for (int i = 0; i < nbytes(sz); i++)
      v = v | (32'(mb[u][a[11:0] + 12'(i)]) << (8 * i));
    return v;
  endfunction

  // One complete access: update the model, drive the request, wait (bounded) for the ack,
  // then check latency, ack direction, load data, the ack pulse width and err_count.
  task automatic access(input int u, input bit rd, input bit wr, input logic [31:0] a,
                        input logic [31:0] d, input logic [1:0] sz, input string tag);
    bit is_store;
    bit mis;
    bit seen;
    int lat;
    is_store = wr;
    mis      = misaligned(a, sz);
    if ((mis || (rd && wr)) && model_err[u] < 65535) model_err[u]++;
    if (is_store) begin
      if (!mis)
        for (int i = 0; i < nbytes(sz); i++) mb[u][a[11:0] + 12'(i)] = d[8*i +: 8];
    end else begin
      model_last[u] = mis ? 32'h0 : model_load(u, a, sz);
    end

    rd_req[u]   = rd;
    wr_req[u]   = wr;
    addr_in[u]  = a;
    wdata_in[u] = d;
    size_in[u]  = sz;
    lat  = 0;
    seen = 0;
    while (!seen && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (rd_ack[u] || wr_ack[u]) seen = 1;
      else if (lat == 1) begin
        // Post-capture changes must be ignored.
        addr_in[u]  = $urandom;
        wdata_in[u] = $urandom;
        size_in[u]  = 2'($urandom_range(0, 3));
      end
    end
    check({tag, ".lat"},  lat, wait_of(u) + 1);
    check({tag, ".rack"}, rd_ack[u], !is_store);
    check({tag, ".wack"}, wr_ack[u], is_store);
    check({tag, ".data"}, data_in[u], model_last[u]);
    rd_req[u] = 1'b0;
    wr_req[u] = 1'b0;
    @(posedge clk); #1;
    check({tag, ".pulse"}, {rd_ack[u], wr_ack[u]}, 2'b00);
    check({tag, ".err"},   err[u], model_err[u]);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          op;
    int          acks;
    logic [31:0] a;
    logic [1:0]  sz;
    bit          rd;
    bit          wr;

    for (int u = 0; u < 2; u++) begin
      rst[u] = 1'b1; rd_req[u] = 1'b0; wr_req[u] = 1'b0;
      addr_in[u] = '0; wdata_in[u] = '0; size_in[u] = 2'd2;
      model_last[u] = 32'h0; model_err[u] = 0;
    end
    for (int i = 0; i < 4096; i++) begin
      mb[0][i] = 8'h00;
      mb[1][i] = 8'h00;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int u = 0; u < 2; u++) begin
      check("rst.rack", rd_ack[u], 1'b0);
      check("rst.wack", wr_ack[u], 1'b0);
      check("rst.data", data_in[u], 32'h0);
      check("rst.err",  err[u], 32'h0);
    end
    rst[0] = 1'b0;
    rst[1] = 1'b0;

    // Known contents for the 128-byte window used below.
    for (int i = 0; i < 32; i++) access(0, 0, 1, 32'(i * 4), $urandom, 2'd2, "init");

    access(0, 0, 1, 32'h10, 32'hDEADBEEF, 2'd2, "rt.st");
    access(0, 1, 0, 32'h10, 32'h0,        2'd2, "rt.ld");
    check("rt.val", data_in[0], 32'hDEADBEEF);

    access(0, 0, 1, 32'h10, 32'h0,        2'd2, "sub.clr");
    access(0, 0, 1, 32'h13, 32'h000000A5, 2'd0, "sub.b");
    access(0, 0, 1, 32'h10, 32'h00001234, 2'd1, "sub.h");
    access(0, 1, 0, 32'h10, 32'h0,        2'd2, "sub.ldw");
    check("sub.word", data_in[0], 32'hA5001234);
    access(0, 1, 0, 32'h13, 32'h0,        2'd0, "sub.ldb");
    check("sub.byte", data_in[0], 32'h000000A5);

    access(0, 0, 1, 32'h22, 32'h12345678, 2'd2, "mis.st");
    access(0, 1, 0, 32'h21, 32'h0,        2'd1, "mis.ld");
    check("mis.zero", data_in[0], 32'h0);
    check("mis.cnt",  err[0], 32'd2);
    access(0, 1, 0, 32'h20, 32'h0,        2'd2, "mis.keep");

    access(0, 1, 1, 32'h40, 32'h55,       2'd2, "dual");
    check("dual.cnt", err[0], 32'd3);
    access(0, 1, 0, 32'h40, 32'h0,        2'd2, "dual.ld");
    check("dual.val", data_in[0], 32'h55);

    access(0, 0, 1, 32'h1000, 32'hCAFEF00D, 2'd2, "wrap.st");
    access(0, 1, 0, 32'h0,    32'h0,        2'd2, "wrap.ld");
    check("wrap.val", data_in[0], 32'hCAFEF00D);

    for (int i = 0; i < 80; i++) begin
      op = $urandom_range(0, 7);
      sz = 2'($urandom_range(0, 3));
      a  = 32'($urandom_range(0, 127));
      if (sz != 2'd3 && $urandom_range(0, 3) != 0) a = a & ~32'(nbytes(sz) - 1);
      if ($urandom_range(0, 3) == 0) a = a | ($urandom & 32'hFFFF_F000);
      rd = (op == 0) || (op >= 4);
      wr = (op <= 3);
      access(0, rd, wr, a, $urandom, sz, "rnd");
    end

    // Reset in the second wait cycle of a store aborts it.
    access(1, 0, 1, 32'h80, 32'h11112222, 2'd2, "abt.pre");
    wr_req[1] = 1'b1; addr_in[1] = 32'h80; wdata_in[1] = 32'h99998888; size_in[1] = 2'd2;
    acks = 0;
    repeat (2) begin
      @(posedge clk); #1;
      if (rd_ack[1] || wr_ack[1]) acks++;
    end
    rst[1] = 1'b1;
    wr_req[1] = 1'b0;
    @(posedge clk); #1;
    rst[1] = 1'b0;
    model_err[1]  = 0;
    model_last[1] = 32'h0;
    check("abt.data", data_in[1], 32'h0);
    check("abt.err",  err[1], 32'h0);
    repeat (8) begin
      @(posedge clk); #1;
      if (rd_ack[1] || wr_ack[1]) acks++;
    end
    check("abt.noack", acks, 32'd0);
    access(1, 1, 0, 32'h80, 32'h0, 2'd2, "abt.ld");
    check("abt.keep", data_in[1], 32'h11112222);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
